// File: rtl/cmp_branch_unit_if.sv
// Execute-stage to compare/branch unit bus: instruction fields in, flag and redirect state out.
// master is the execute stage; slave is cmp_branch_unit.
interface cmp_branch_unit_if #(
    parameter int DATA_W = 4,
    parameter int PC_W   = 8
);
    logic              valid_in;
    logic              is_cmp;
    logic              is_branch;
    logic [DATA_W-1:0] cmp_result;
    logic              cmp_zero;
    logic [1:0]        br_cond;
    logic [PC_W-1:0]   br_target;

    logic              z_flag;
    logic [DATA_W-1:0] last_result;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              flush;
    logic [7:0]        taken_cnt;

    modport master (
        output valid_in, is_cmp, is_branch, cmp_result, cmp_zero, br_cond, br_target,
        input  z_flag, last_result, redirect, redirect_pc, flush, taken_cnt
    );

    modport slave (
        input  valid_in, is_cmp, is_branch, cmp_result, cmp_zero, br_cond, br_target,
        output z_flag, last_result, redirect, redirect_pc, flush, taken_cnt
    );
endinterface

// File: rtl/cmp_branch_unit.sv
// Compare flag register plus branch resolver: a taken branch redirects fetch for one cycle
// and squashes younger instructions for FLUSH_CYC cycles.
module cmp_branch_unit #(
    parameter int DATA_W    = 4,
    parameter int PC_W      = 8,
    parameter int FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    cmp_branch_unit_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);

    state_t            state, state_nxt;
    logic [3:0]        flush_cnt, flush_cnt_nxt;
    logic              z_flag_q;
    logic [DATA_W-1:0] last_result_q;
    logic              redirect_q;
    logic [PC_W-1:0]   redirect_pc_q;
    logic [7:0]        taken_cnt_q;

    logic accept;
    logic taken;
    logic br_fire;

    assign accept = bus.valid_in && (state == IDLE);

    // Branch condition uses the registered flag, so a compare in the same cycle cannot affect it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        taken = 1'b0;
        unique case (bus.br_cond)
            2'b00: taken = 1'b1;
            2'b01: taken = z_flag_q;
            2'b10: taken = ~z_flag_q;
            2'b11: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

    assign br_fire = accept && bus.is_branch && taken;

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        unique case (state)
            IDLE: begin
                if (br_fire) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (flush_cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    flush_cnt_nxt = flush_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt     = IDLE;
                flush_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state         <= IDLE;
            flush_cnt     <= 4'd0;
            z_flag_q      <= 1'b0;
            last_result_q <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            taken_cnt_q   <= 8'd0;
        end else begin
            state      <= state_nxt;
            flush_cnt  <= flush_cnt_nxt;
            redirect_q <= br_fire;
            if (accept && bus.is_cmp) begin
                z_flag_q      <= bus.cmp_zero;
                last_result_q <= bus.cmp_result;
            end
            if (br_fire) begin
                redirect_pc_q <= bus.br_target;
                taken_cnt_q   <= taken_cnt_q + 8'd1;
            end
        end
    end

    assign bus.z_flag      = z_flag_q;
    assign bus.last_result = last_result_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.flush       = (state == FLUSH);
    assign bus.taken_cnt   = taken_cnt_q;
endmodule

// File: tb/tb_cmp_branch_unit.sv
// Directed bench for cmp_branch_unit at default parameters (DATA_W=4, PC_W=8, FLUSH_CYC=2).
module tb_cmp_branch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    cmp_branch_unit_if #(.DATA_W(4), .PC_W(8)) bus ();

    cmp_branch_unit #(.DATA_W(4), .PC_W(8), .FLUSH_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.valid_in   = 1'b0;
        bus.is_cmp     = 1'b0;
        bus.is_branch  = 1'b0;
        bus.cmp_result = 4'h0;
        bus.cmp_zero   = 1'b0;
        bus.br_cond    = 2'b11;
        bus.br_target  = 8'h00;
    endtask

    task automatic drive(input logic c, input logic b, input logic [3:0] res, input logic zero,
                         input logic [1:0] cond, input logic [7:0] tgt);
        bus.valid_in   = 1'b1;
        bus.is_cmp     = c;
        bus.is_branch  = b;
        bus.cmp_result = res;
        bus.cmp_zero   = zero;
        bus.br_cond    = cond;
        bus.br_target  = tgt;
    endtask

    initial begin
        // Reset with a taken-looking branch presented; it must be ignored.
        drive(1'b1, 1'b1, 4'hA, 1'b1, 2'b00, 8'hFF);
        rst = 1'b1;
        cycle();
        cycle();
        check("rst_z_flag", 32'(bus.z_flag), 32'd0);
        check("rst_last_result", 32'(bus.last_result), 32'd0);
        check("rst_redirect", 32'(bus.redirect), 32'd0);
        check("rst_redirect_pc", 32'(bus.redirect_pc), 32'd0);
        check("rst_flush", 32'(bus.flush), 32'd0);
        check("rst_taken_cnt", 32'(bus.taken_cnt), 32'd0);
        rst = 1'b0;

        // Compare zero, then equal-branch taken to 3C.
        drive(1'b1, 1'b0, 4'h0, 1'b1, 2'b11, 8'h00);
        cycle();
        check("cmp1_z_flag", 32'(bus.z_flag), 32'd1);
        check("cmp1_redirect", 32'(bus.redirect), 32'd0);
        drive(1'b0, 1'b1, 4'h0, 1'b0, 2'b01, 8'h3C);
        cycle();
        check("br1_redirect", 32'(bus.redirect), 32'd1);
        check("br1_redirect_pc", 32'(bus.redirect_pc), 32'h3C);
        check("br1_flush_a", 32'(bus.flush), 32'd1);
        check("br1_taken_cnt", 32'(bus.taken_cnt), 32'd1);
        idle_in();
        cycle();
        check("br1_redirect_pulse", 32'(bus.redirect), 32'd0);
        check("br1_flush_b", 32'(bus.flush), 32'd1);
        check("br1_pc_hold", 32'(bus.redirect_pc), 32'h3C);
        cycle();
        check("br1_flush_end", 32'(bus.flush), 32'd0);

        // Nonzero compare, equal-branch not taken, zero-bubble follow-on.
        drive(1'b1, 1'b0, 4'h5, 1'b0, 2'b11, 8'h00);
        cycle();
        check("cmp2_z_flag", 32'(bus.z_flag), 32'd0);
        check("cmp2_last_result", 32'(bus.last_result), 32'h5);
        drive(1'b0, 1'b1, 4'h0, 1'b0, 2'b01, 8'h55);
        cycle();
        check("br2_redirect", 32'(bus.redirect), 32'd0);
        check("br2_flush", 32'(bus.flush), 32'd0);
        drive(1'b1, 1'b0, 4'h7, 1'b0, 2'b11, 8'h00);
        cycle();
        check("cmp3_last_result", 32'(bus.last_result), 32'h7);
        check("cmp3_taken_cnt", 32'(bus.taken_cnt), 32'd1);

        // Combined compare+branch sees the old flag (0): not taken, flag then 1.
        drive(1'b1, 1'b1, 4'h9, 1'b1, 2'b01, 8'h77);
        cycle();
        check("combo_redirect", 32'(bus.redirect), 32'd0);
        check("combo_z_flag", 32'(bus.z_flag), 32'd1);
        check("combo_flush", 32'(bus.flush), 32'd0);
        check("combo_pc_hold", 32'(bus.redirect_pc), 32'h3C);

        // Not-equal branch with flag=1 is not taken.
        drive(1'b0, 1'b1, 4'h0, 1'b0, 2'b10, 8'h66);
        cycle();
        check("ne_z1_redirect", 32'(bus.redirect), 32'd0);

        // Flag 0, not-equal branch taken; inputs during FLUSH must be ignored.
        drive(1'b1, 1'b0, 4'h2, 1'b0, 2'b11, 8'h00);
        cycle();
        drive(1'b0, 1'b1, 4'h0, 1'b0, 2'b10, 8'hA5);
        cycle();
        check("ne_redirect", 32'(bus.redirect), 32'd1);
        check("ne_redirect_pc", 32'(bus.redirect_pc), 32'hA5);
        check("ne_taken_cnt", 32'(bus.taken_cnt), 32'd2);
        drive(1'b1, 1'b1, 4'hF, 1'b1, 2'b00, 8'h11);
        cycle();
        check("fl_redirect_a", 32'(bus.redirect), 32'd0);
        check("fl_z_flag_a", 32'(bus.z_flag), 32'd0);
        check("fl_flush_a", 32'(bus.flush), 32'd1);
        cycle();
        check("fl_redirect_b", 32'(bus.redirect), 32'd0);
        check("fl_z_flag_b", 32'(bus.z_flag), 32'd0);
        check("fl_last_result", 32'(bus.last_result), 32'h2);
        check("fl_taken_cnt", 32'(bus.taken_cnt), 32'd2);
        check("fl_flush_end", 32'(bus.flush), 32'd0);
        check("fl_pc_hold", 32'(bus.redirect_pc), 32'hA5);

        // Earliest back-to-back taken branch (N+FLUSH_CYC+1), then reset in its first FLUSH cycle.
        drive(1'b0, 1'b1, 4'h0, 1'b0, 2'b00, 8'h42);
        cycle();
        check("b2b_redirect", 32'(bus.redirect), 32'd1);
        check("b2b_redirect_pc", 32'(bus.redirect_pc), 32'h42);
        check("b2b_taken_cnt", 32'(bus.taken_cnt), 32'd3);
        check("b2b_flush", 32'(bus.flush), 32'd1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 4'h3, 1'b1, 2'b00, 8'h99);
        cycle();
        check("rstfl_flush", 32'(bus.flush), 32'd0);
        check("rstfl_redirect", 32'(bus.redirect), 32'd0);
        check("rstfl_taken_cnt", 32'(bus.taken_cnt), 32'd0);
        check("rstfl_z_flag", 32'(bus.z_flag), 32'd0);
        rst = 1'b0;
        idle_in();
        cycle();
        check("rstfl_no_accept", 32'(bus.redirect), 32'd0);
        check("rstfl_pc", 32'(bus.redirect_pc), 32'd0);

        // 256 always-taken branches wrap taken_cnt back to 0.
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 4'h0, 1'b0, 2'b00, 8'(i));
            cycle();
            idle_in();
            cycle();
            cycle();
            if (i == 254) check("wrap_255", 32'(bus.taken_cnt), 32'd255);
        end
        check("wrap_zero", 32'(bus.taken_cnt), 32'd0);
        check("wrap_last_pc", 32'(bus.redirect_pc), 32'hFF);
        check("wrap_flush_idle", 32'(bus.flush), 32'd0);

        // Never-condition branch does nothing.
        drive(1'b0, 1'b1, 4'h0, 1'b0, 2'b11, 8'hEE);
        cycle();
        check("never_redirect", 32'(bus.redirect), 32'd0);
        check("never_flush", 32'(bus.flush), 32'd0);
        check("never_taken_cnt", 32'(bus.taken_cnt), 32'd0);
        idle_in();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
